// File: rtl/resp_mon_pkg.sv
// Shared types and constants for the response signature monitor: FSM states,
// default MISR polynomial/seed and toggle-counter sizing.
package resp_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } mon_state_e;

  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  localparam int                  TOGGLE_W   = 16;
  localparam logic [TOGGLE_W-1:0] TOGGLE_MAX = {TOGGLE_W{1'b1}};

  localparam int WIN_CNT_W = 16;

endpackage

// File: rtl/resp_signature_monitor_misr_compactor.sv
// Galois-form multiple-input signature register: shifts left, folds the MSB
// back through POLY and XORs the zero-extended response into the low bits.
module misr_compactor #(
  parameter int                MISR_W = 16,
  parameter int                RESP_W = 1,
  parameter logic [MISR_W-1:0] POLY   = '0,
  parameter logic [MISR_W-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_seed,
  input  logic              enable,
  input  logic [RESP_W-1:0] data,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;
  logic [MISR_W-1:0] data_ext;
  logic [MISR_W-1:0] step;

  genvar gi;
  generate
    for (gi = 0; gi < MISR_W; gi++) begin : g_ext
      if (gi < RESP_W) begin : g_data
        assign data_ext[gi] = data[gi];
      end else begin : g_zero
        assign data_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Feedback tap applied only when the bit being shifted out is set.
  assign step = (sig_q << 1) ^ (sig_q[MISR_W-1] ? POLY : '0) ^ data_ext;

  always_comb begin
    sig_d = sig_q;
    if (load_seed) begin
      sig_d = SEED;
    end else if (enable) begin
      sig_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/resp_signature_monitor.sv
// Observes a subcircuit's response over a fixed window: compacts it into a
// MISR signature, counts bit-0 toggles and flags a mismatch against golden.
module resp_signature_monitor
  import resp_mon_pkg::*;
#(
  parameter int                RESP_W  = 1,
  parameter int                MISR_W  = 16,
  parameter logic [MISR_W-1:0] POLY    = MISR_W'(DEF_POLY),
  parameter logic [MISR_W-1:0] SEED    = MISR_W'(DEF_SEED),
  parameter int                WIN_LEN = 1000
) (
  input  logic                I1470_clk,
  input  logic                I1477_rst,
  input  logic                start,
  input  logic                resp_valid,
  input  logic [RESP_W-1:0]   resp_in,
  input  logic [MISR_W-1:0]   golden_sig,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [MISR_W-1:0]   sig_out,
  output logic [TOGGLE_W-1:0] toggle_cnt
);

  localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WIN_LEN - 1);

  mon_state_e            state_q, state_d;
  logic [WIN_CNT_W-1:0]  count_q, count_d;
  logic [TOGGLE_W-1:0]   toggle_q, toggle_d;
  logic                  prev_bit_q, prev_bit_d;
  logic                  first_q, first_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mismatch_q, mismatch_d;

  logic                  misr_load;
  logic                  misr_en;
  logic [MISR_W-1:0]     sig;

  assign misr_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign misr_en   = resp_valid && (state_q == RUN);

  misr_compactor #(
    .MISR_W (MISR_W),
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk       (I1470_clk),
    .srst      (I1477_rst),
    .load_seed (misr_load),
    .enable    (misr_en),
    .data      (resp_in),
    .sig       (sig)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    toggle_d   = toggle_q;
    prev_bit_d = prev_bit_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mismatch_d = mismatch_q;

    case (state_q)
      IDLE, DONE: begin
        // A sample arriving together with start is intentionally dropped.
        if (start) begin
          state_d    = RUN;
          count_d    = '0;
          toggle_d   = '0;
          first_d    = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          mismatch_d = 1'b0;
        end
      end
      RUN: begin
        if (resp_valid) begin
          count_d    = count_q + WIN_CNT_W'(1);
          prev_bit_d = resp_in[0];
          first_d    = 1'b0;
          if (!first_q && (resp_in[0] != prev_bit_q) && (toggle_q != TOGGLE_MAX)) begin
            toggle_d = toggle_q + TOGGLE_W'(1);
          end
          if (count_q == WIN_LAST) begin
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        mismatch_d = (sig != golden_sig);
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      toggle_q   <= '0;
      prev_bit_q <= 1'b0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      toggle_q   <= toggle_d;
      prev_bit_q <= prev_bit_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mismatch   = mismatch_q;
  assign sig_out    = sig;
  assign toggle_cnt = toggle_q;

endmodule

// File: tb/tb_resp_signature_monitor.sv
// Directed bench: a table of 4-sample windows on a 4-bit MISR, plus hand
// sequences for reset, restart, WIN_LEN=1, seeded feedback and long windows.
module tb_resp_signature_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: MISR_W=4, POLY=3, SEED=0, WIN_LEN=4
  logic       a_start, a_valid, a_resp, a_busy, a_done, a_mm;
  logic [3:0] a_golden, a_sig;
  logic [15:0] a_tog;
  // Instance B: defaults, WIN_LEN=65535
  logic        b_start, b_valid, b_resp, b_busy, b_done, b_mm;
  logic [15:0] b_golden, b_sig, b_tog;
  // Instance C: MISR_W=4, POLY=3, SEED=0, WIN_LEN=1
  logic       c_start, c_valid, c_resp, c_busy, c_done, c_mm;
  logic [3:0] c_golden, c_sig;
  logic [15:0] c_tog;
  // Instance D: MISR_W=4, POLY=3, SEED=C, WIN_LEN=2
  logic       d_start, d_valid, d_resp, d_busy, d_done, d_mm;
  logic [3:0] d_golden, d_sig;
  logic [15:0] d_tog;

  resp_signature_monitor #(.RESP_W(1), .MISR_W(4), .POLY(4'h3), .SEED(4'h0), .WIN_LEN(4)) u_a (
    .I1470_clk(clk), .I1477_rst(rst), .start(a_start), .resp_valid(a_valid),
    .resp_in(a_resp), .golden_sig(a_golden), .busy(a_busy), .done(a_done),
    .mismatch(a_mm), .sig_out(a_sig), .toggle_cnt(a_tog));

  resp_signature_monitor #(.WIN_LEN(65535)) u_b (
    .I1470_clk(clk), .I1477_rst(rst), .start(b_start), .resp_valid(b_valid),
    .resp_in(b_resp), .golden_sig(b_golden), .busy(b_busy), .done(b_done),
    .mismatch(b_mm), .sig_out(b_sig), .toggle_cnt(b_tog));

  resp_signature_monitor #(.RESP_W(1), .MISR_W(4), .POLY(4'h3), .SEED(4'h0), .WIN_LEN(1)) u_c (
    .I1470_clk(clk), .I1477_rst(rst), .start(c_start), .resp_valid(c_valid),
    .resp_in(c_resp), .golden_sig(c_golden), .busy(c_busy), .done(c_done),
    .mismatch(c_mm), .sig_out(c_sig), .toggle_cnt(c_tog));

  resp_signature_monitor #(.RESP_W(1), .MISR_W(4), .POLY(4'h3), .SEED(4'hC), .WIN_LEN(2)) u_d (
    .I1470_clk(clk), .I1477_rst(rst), .start(d_start), .resp_valid(d_valid),
    .resp_in(d_resp), .golden_sig(d_golden), .busy(d_busy), .done(d_done),
    .mismatch(d_mm), .sig_out(d_sig), .toggle_cnt(d_tog));

  typedef struct {
    string       name;
    logic [3:0]  samples;    // sent MSB first
    logic [7:0]  valid_pat;  // bit (cycle % 8) = resp_valid
    logic [3:0]  golden;
    logic [3:0]  exp_sig;
    logic        exp_mm;
    logic [15:0] exp_tog;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_a(input vec_t v);
    int sent;
    int cyc;
    a_golden = v.golden;
    a_start  = 1'b1;
    a_valid  = 1'b1;
    a_resp   = 1'b1;
    tick();
    check({v.name, " start busy"}, a_busy, 1);
    check({v.name, " start sig"}, a_sig, 0);
    check({v.name, " start done"}, a_done, 0);
    a_start = 1'b0;
    sent = 0;
    cyc  = 0;
    while (sent < 4 && cyc < 64) begin
      if (v.valid_pat[cyc % 8]) begin
        a_valid = 1'b1;
        a_resp  = v.samples[3 - sent];
        sent++;
      end else begin
        a_valid = 1'b0;
        a_resp  = 1'b1;
      end
      cyc++;
      tick();
    end
    a_valid = 1'b0;
    check({v.name, " compare busy"}, a_busy, 1);
    check({v.name, " compare done"}, a_done, 0);
    tick();
    check({v.name, " done"}, a_done, 1);
    check({v.name, " busy"}, a_busy, 0);
    check({v.name, " mismatch"}, a_mm, v.exp_mm);
    check({v.name, " sig"}, a_sig, v.exp_sig);
    check({v.name, " toggles"}, a_tog, v.exp_tog);
    a_valid = 1'b1;
    a_resp  = 1'b1;
    tick();
    tick();
    a_valid = 1'b0;
    check({v.name, " sig held"}, a_sig, v.exp_sig);
    check({v.name, " done held"}, a_done, 1);
    check({v.name, " mm held"}, a_mm, v.exp_mm);
  endtask

  initial begin
    vecs[0] = '{"basic",    4'b1011, 8'hFF, 4'hB, 4'hB, 1'b0, 16'd2};
    vecs[1] = '{"gold_bad", 4'b1011, 8'hFF, 4'hA, 4'hB, 1'b1, 16'd2};
    vecs[2] = '{"gaps",     4'b1011, 8'h55, 4'hB, 4'hB, 1'b0, 16'd2};
    vecs[3] = '{"zeros",    4'b0000, 8'hFF, 4'h0, 4'h0, 1'b0, 16'd0};
    vecs[4] = '{"ones",     4'b1111, 8'hFF, 4'hF, 4'hF, 1'b0, 16'd0};
    vecs[5] = '{"alt0101",  4'b0101, 8'h33, 4'h5, 4'h5, 1'b0, 16'd3};
    vecs[6] = '{"one_8",    4'b1000, 8'hFF, 4'h0, 4'h8, 1'b1, 16'd1};
    vecs[7] = '{"e_gaps",   4'b1110, 8'h49, 4'hE, 4'hE, 1'b0, 16'd1};

    rst = 1'b1;
    a_start = 0; a_valid = 0; a_resp = 0; a_golden = 0;
    b_start = 0; b_valid = 0; b_resp = 0; b_golden = 0;
    c_start = 0; c_valid = 0; c_resp = 0; c_golden = 0;
    d_start = 0; d_valid = 0; d_resp = 0; d_golden = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst sig", a_sig, 0);
    check("rst toggles", a_tog, 0);
    check("rst busy", a_busy, 0);
    check("rst done", a_done, 0);
    check("rst mismatch", a_mm, 0);
    check("rst seed D", d_sig, 4'hC);

    // Inputs in IDLE are ignored.
    a_valid = 1'b1; a_resp = 1'b1;
    tick();
    a_valid = 1'b0;
    check("idle ignore sig", a_sig, 0);
    check("idle ignore busy", a_busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_a(vecs[i]);
    end

    // Reset mid-window abandons the run.
    a_golden = 4'hB;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_resp = 1'b1; tick();
    check("midrst s1", a_sig, 4'h1);
    a_resp = 1'b0; tick();
    check("midrst s2", a_sig, 4'h2);
    check("midrst tog", a_tog, 1);
    a_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("midrst sig", a_sig, 0);
    check("midrst tog0", a_tog, 0);
    check("midrst done", a_done, 0);
    check("midrst busy", a_busy, 0);
    tick();
    check("midrst no done", a_done, 0);
    run_a(vecs[0]);

    // Start in RUN is ignored; signature sequence 1,2,5,B.
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_resp = 1'b1; tick();
    check("seq s1", a_sig, 4'h1);
    a_start = 1'b1; a_resp = 1'b0; tick(); a_start = 1'b0;
    check("seq s2 start ign", a_sig, 4'h2);
    check("seq busy", a_busy, 1);
    a_resp = 1'b1; tick();
    check("seq s3", a_sig, 4'h5);
    tick();
    check("seq s4", a_sig, 4'hB);
    a_valid = 1'b0; tick();
    check("seq done", a_done, 1);
    check("seq mm", a_mm, 0);
    check("seq tog", a_tog, 2);

    // Start in DONE restarts and clears.
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("restart done", a_done, 0);
    check("restart tog", a_tog, 0);
    check("restart sig", a_sig, 0);
    check("restart busy", a_busy, 1);

    // WIN_LEN=1.
    c_golden = 4'h1;
    c_start = 1'b1; tick(); c_start = 1'b0;
    c_valid = 1'b1; c_resp = 1'b1; tick(); c_valid = 1'b0;
    check("w1 compare busy", c_busy, 1);
    check("w1 compare done", c_done, 0);
    tick();
    check("w1 done", c_done, 1);
    check("w1 sig", c_sig, 4'h1);
    check("w1 mm", c_mm, 0);

    // Nonzero seed exercising the feedback tap: C -> A -> 7.
    d_golden = 4'h7;
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("seed load", d_sig, 4'hC);
    d_valid = 1'b1; d_resp = 1'b1; tick();
    check("fb s1", d_sig, 4'hA);
    d_resp = 1'b0; tick(); d_valid = 1'b0;
    check("fb s2", d_sig, 4'h7);
    tick();
    check("fb done", d_done, 1);
    check("fb mm", d_mm, 0);

    // Longest window with alternating response.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      b_valid = 1'b1;
      b_resp  = i[0];
      tick();
      if (i == 99) check("long tog 99", b_tog, 16'd99);
    end
    b_valid = 1'b0;
    check("long compare done", b_done, 0);
    tick();
    check("long done", b_done, 1);
    check("long tog", b_tog, 16'hFFFE);
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("long restart tog", b_tog, 0);
    check("long restart done", b_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
